pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYC, default 2, the number of multiplier busy cycles.
REQ-002 SHALL have parameter DIV_CYC, default 33, the number of divider busy cycles.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports id_rs_ren, id_rt_ren, input, 1 bit each: the ID instruction reads GPR[rs] / GPR[rt].
REQ-006 SHALL have ports id_rs, id_rt, input, 5 bits each: the ID source register numbers.
REQ-007 SHALL have ports ex_load, ex_regwen, ex_mult, ex_div, input, 1 bit each: EX-stage instruction attributes.
REQ-008 SHALL have port ex_wreg, input, 5 bits: the EX destination register.
REQ-009 SHALL have ports mem_req, mem_ok, input, 1 bit each: the MEM-stage data access is outstanding / completes this cycle.
REQ-010 SHALL have port exc_flush, input, 1 bit: an exception or eret commits; flush the pipeline.
REQ-011 SHALL have ports if_id_stall, id_ex_stall, ex_mem_stall, output, 1 bit each: hold the corresponding segment register.
REQ-012 SHALL have ports if_id_refresh, id_ex_refresh, ex_mem_refresh, output, 1 bit each: clear the corresponding segment register to a bubble.
REQ-013 SHALL have ports md_start, md_abort, output, 1 bit each: one-cycle pulses to the mult/div unit.
REQ-014 SHALL have port md_busy, output, 1 bit: the mult/div unit is occupied.

Function
REQ-015 SHALL implement an FSM with states IDLE, MUL, DIV and DONE, plus a 6-bit down-counter cnt.
REQ-016 SHALL, in IDLE, when ex_mult or ex_div is 1 and exc_flush is 0: pulse md_start, load cnt with MUL_CYC-1 or DIV_CYC-1, and go to MUL or DIV; ex_div wins if both are set.
REQ-017 SHALL, in MUL or DIV: decrement cnt each cycle and go to DONE when cnt equals 0.
REQ-018 SHALL, in DONE: go to IDLE only when the memory wait of REQ-022 is 0; otherwise remain in DONE, so that an instruction held in EX never restarts the unit.
REQ-019 SHALL drive md_busy as 1 in MUL and DIV, and as 0 in IDLE and DONE.
REQ-020 SHALL, during the md_start cycle and all MUL/DIV cycles: assert if_id_stall, id_ex_stall and ex_mem_refresh.
REQ-021 SHALL detect load-use as: ex_load and ex_regwen and ex_wreg is not 0 and ((id_rs_ren and id_rs equals ex_wreg) or (id_rt_ren and id_rt equals ex_wreg)); on load-use, assert if_id_stall and id_ex_refresh.
REQ-022 SHALL define memory wait as mem_req and not mem_ok; on memory wait, assert if_id_stall, id_ex_stall and ex_mem_stall, and suppress every refresh except the flush refresh.
REQ-023 SHALL let the mult/div counter continue counting during memory wait.
REQ-024 SHALL apply the priority exc_flush > memory wait > mult/div > load-use.
REQ-025 SHALL, on exc_flush: assert all three refreshes, deassert all stalls, and suppress md_start.
REQ-026 SHALL, on exc_flush in MUL or DIV: also pulse md_abort, force the state to IDLE and clear cnt.
REQ-027 SHALL drive all outputs combinationally from state, cnt and inputs, with no registered output delay.
REQ-028 SHALL never assert a stall and a refresh for the same segment in the same cycle.

Reset
REQ-029 SHALL, when reset is 1 at a clock edge, set the state to IDLE and cnt to 0, regardless of operation in progress; a mid-DIV reset therefore drops md_busy the next cycle with no md_abort.
REQ-030 SHALL drive every output to 0 while in reset state with all inputs at 0.

Structure
REQ-031 SHALL take the FSM state encodings and the MUL_CYC/DIV_CYC defaults from the shared header head.vh.
REQ-032 SHALL place the load-use comparison of REQ-021 in one combinational sub-module, hazard_detect.

Verification
REQ-033 SHALL cover load-use: ex_load=1, ex_wreg=5, id_rs_ren=1, id_rs=5 -> one cycle of if_id_stall=1 and id_ex_refresh=1; with ex_wreg=0 -> no action.
REQ-034 SHALL cover DIV: ex_div=1 in IDLE -> md_start for 1 cycle; md_busy for 33 cycles; stalls for 34 cycles; DONE then IDLE, with no second md_start.
REQ-035 SHALL cover mid-flight flush: exc_flush at DIV cycle 10 -> md_abort=1, all refreshes=1, state IDLE next cycle.
REQ-036 SHALL cover memory wait over DONE: mem_req=1, mem_ok=0 spanning the end of MUL -> the FSM holds DONE and all three stalls stay 1 until mem_ok=1, then IDLE.
REQ-037 SHALL cover simultaneous events: load-use, ex_mult and memory wait in the same cycle -> only memory-wait stalls, with no refresh.
REQ-038 SHALL cover reset during MUL: reset=1 -> next cycle state IDLE, cnt=0, all outputs 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard / mult-div controller.
// State encodings, cycle defaults and the segment bundle used by stall/refresh.
package pipe_ctrl_pkg;

  localparam int MUL_CYC_DEF = 2;
  localparam int DIV_CYC_DEF = 33;
  localparam int CNT_W       = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // One bit per pipeline segment register.
  typedef struct packed {
    logic if_id;
    logic id_ex;
    logic ex_mem;
  } seg_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and pipe_ctrl.
// master: datapath side (drives hazard inputs); slave: the controller.
interface pipe_ctrl_if;

  logic       id_rs_ren;
  logic       id_rt_ren;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       ex_load;
  logic       ex_regwen;
  logic       ex_mult;
  logic       ex_div;
  logic [4:0] ex_wreg;
  logic       mem_req;
  logic       mem_ok;
  logic       exc_flush;

  logic       if_id_stall;
  logic       id_ex_stall;
  logic       ex_mem_stall;
  logic       if_id_refresh;
  logic       id_ex_refresh;
  logic       ex_mem_refresh;
  logic       md_start;
  logic       md_abort;
  logic       md_busy;

  modport master (
    output id_rs_ren, id_rt_ren, id_rs, id_rt,
    output ex_load, ex_regwen, ex_mult, ex_div,
    output ex_wreg, mem_req, mem_ok, exc_flush,
    input  if_id_stall, id_ex_stall, ex_mem_stall,
    input  if_id_refresh, id_ex_refresh,
    input  ex_mem_refresh,
    input  md_start, md_abort, md_busy
  );

  modport slave (
    input  id_rs_ren, id_rt_ren, id_rs, id_rt,
    input  ex_load, ex_regwen, ex_mult, ex_div,
    input  ex_wreg, mem_req, mem_ok, exc_flush,
    output if_id_stall, id_ex_stall, ex_mem_stall,
    output if_id_refresh, id_ex_refresh,
    output ex_mem_refresh,
    output md_start, md_abort, md_busy
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: EX load writing a GPR that ID reads.
// Ports: ID read enables/regs, EX load attributes in; load_use_o out.
module hazard_detect (
  input  logic       id_rs_ren_i,
  input  logic       id_rt_ren_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       ex_load_i,
  input  logic       ex_regwen_i,
  input  logic [4:0] ex_wreg_i,
  output logic       load_use_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_rs_ren_i && (id_rs_i == ex_wreg_i);
  assign rt_hit = id_rt_ren_i && (id_rt_i == ex_wreg_i);

  // r0 is hardwired, so a load "into" it never creates a hazard.
  assign load_use_o = ex_load_i && ex_regwen_i &&
                      (ex_wreg_i != 5'd0) &&
                      (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/refresh control plus mult/div busy sequencing.
// Ports: clk, reset (sync, active-high), pc (pipe_ctrl_if.slave).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYC = MUL_CYC_DEF,
  parameter int DIV_CYC = DIV_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  pipe_ctrl_if.slave pc
);

  localparam logic [CNT_W-1:0] MUL_LD =
    CNT_W'(MUL_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LD =
    CNT_W'(DIV_CYC - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_use;
  logic mem_wait;
  logic busy;
  logic start;
  logic abort;
  seg_t stall;
  seg_t refresh;

  hazard_detect u_hazard (
    .id_rs_ren_i (pc.id_rs_ren),
    .id_rt_ren_i (pc.id_rt_ren),
    .id_rs_i     (pc.id_rs),
    .id_rt_i     (pc.id_rt),
    .ex_load_i   (pc.ex_load),
    .ex_regwen_i (pc.ex_regwen),
    .ex_wreg_i   (pc.ex_wreg),
    .load_use_o  (load_use)
  );

  assign mem_wait = pc.mem_req && !pc.mem_ok;
  assign busy     = (state_q == ST_MUL) ||
                    (state_q == ST_DIV);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A mult/div waiting in EX behind a stalled MEM must
  // not launch; it starts once the memory wait clears.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    abort   = 1'b0;
    if (pc.exc_flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      abort   = busy;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if ((pc.ex_mult || pc.ex_div) && !mem_wait) begin
            start   = 1'b1;
            state_d = pc.ex_div ? ST_DIV : ST_MUL;
            cnt_d   = pc.ex_div ? DIV_LD : MUL_LD;
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt_q == '0) state_d = ST_DONE;
          else cnt_d = cnt_q - 1'b1;
        end
        ST_DONE: begin
          if (!mem_wait) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stall   = '0;
    refresh = '0;
    if (pc.exc_flush) begin
      refresh = '{1'b1, 1'b1, 1'b1};
    end else if (mem_wait) begin
      stall = '{1'b1, 1'b1, 1'b1};
    end else if (start || busy) begin
      stall          = '{1'b1, 1'b1, 1'b0};
      refresh.ex_mem = 1'b1;
    end else if (load_use) begin
      stall.if_id   = 1'b1;
      refresh.id_ex = 1'b1;
    end
  end

  assign pc.if_id_stall    = stall.if_id;
  assign pc.id_ex_stall    = stall.id_ex;
  assign pc.ex_mem_stall   = stall.ex_mem;
  assign pc.if_id_refresh  = refresh.if_id;
  assign pc.id_ex_refresh  = refresh.id_ex;
  assign pc.ex_mem_refresh = refresh.ex_mem;
  assign pc.md_start       = start;
  assign pc.md_abort       = abort;
  assign pc.md_busy        = busy;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: reference model + directed vectors.
// Model tracks remaining busy cycles and a done flag, not the RTL FSM.
module tb_pipe_ctrl;

  localparam int MUL_N = 2;
  localparam int DIV_N = 33;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;

  pipe_ctrl_if pif ();

  pipe_ctrl #(.MUL_CYC(MUL_N), .DIV_CYC(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .pc    (pif)
  );

  always #5 clk = ~clk;

  // {ifs,ids,exs,ifr,idr,exr,start,abort,busy}
  logic [8:0] dut_o;
  assign dut_o = {pif.if_id_stall, pif.id_ex_stall,
                  pif.ex_mem_stall, pif.if_id_refresh,
                  pif.id_ex_refresh, pif.ex_mem_refresh,
                  pif.md_start, pif.md_abort, pif.md_busy};

  int m_left = 0;
  bit m_done = 1'b0;

  function automatic bit m_mw();
    return pif.mem_req && !pif.mem_ok;
  endfunction

  function automatic bit m_start();
    bit idle;
    idle = (m_left == 0) && !m_done;
    return idle && (pif.ex_mult || pif.ex_div) &&
           !pif.exc_flush && !m_mw();
  endfunction

  function automatic bit m_lu();
    bit hit;
    hit = (pif.id_rs_ren && pif.id_rs == pif.ex_wreg) ||
          (pif.id_rt_ren && pif.id_rt == pif.ex_wreg);
    return pif.ex_load && pif.ex_regwen &&
           pif.ex_wreg != 5'd0 && hit;
  endfunction

  function automatic logic [8:0] exp_outs();
    bit busy;
    bit st;
    logic [2:0] s;
    logic [2:0] r;
    busy = m_left > 0;
    st   = m_start();
    s    = 3'b000;
    r    = 3'b000;
    if (pif.exc_flush) r = 3'b111;
    else if (m_mw()) s = 3'b111;
    else if (st || busy) begin
      s = 3'b110;
      r = 3'b001;
    end else if (m_lu()) begin
      s = 3'b100;
      r = 3'b010;
    end
    return {s, r, st, pif.exc_flush && busy, busy};
  endfunction

  always @(posedge clk) begin
    if (reset || pif.exc_flush) begin
      m_left <= 0;
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_done <= 1'b1;
    end else if (m_done) begin
      if (!m_mw()) m_done <= 1'b0;
    end else if (m_start()) begin
      m_left <= pif.ex_div ? DIV_N : MUL_N;
    end
  end

  task automatic chk(string nm, int got, int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) chk("model", int'(dut_o), int'(exp_outs()));
  end

  task automatic clr();
    pif.id_rs_ren = 0; pif.id_rt_ren = 0;
    pif.id_rs = 0; pif.id_rt = 0;
    pif.ex_load = 0; pif.ex_regwen = 0;
    pif.ex_mult = 0; pif.ex_div = 0;
    pif.ex_wreg = 0; pif.mem_req = 0;
    pif.mem_ok = 0; pif.exc_flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  int n_st, n_bz, n_sl;

  initial begin
    reset = 1'b1;
    clr();
    tick();
    chk_en = 1'b1;
    smp();
    chk("reset_outs", int'(dut_o), 0);
    tick();
    reset = 1'b0;
    tick();

    // load-use on rs
    pif.ex_load = 1; pif.ex_regwen = 1;
    pif.ex_wreg = 5; pif.id_rs_ren = 1; pif.id_rs = 5;
    smp();
    chk("lu_rs", int'(dut_o), 9'b100_010_000);
    tick();
    pif.ex_wreg = 0; pif.id_rs = 0;
    smp();
    chk("lu_r0", int'(dut_o), 0);
    tick();
    clr();
    pif.ex_load = 1; pif.ex_regwen = 1; pif.ex_wreg = 7;
    pif.id_rt_ren = 1; pif.id_rt = 7;
    tick();
    pif.ex_regwen = 0;
    tick();
    pif.ex_regwen = 1; pif.id_rt_ren = 0;
    tick();
    clr();
    tick();

    // full DIV
    n_st = 0; n_bz = 0; n_sl = 0;
    for (int i = 0; i < 38; i++) begin
      pif.ex_div = (i < 35);
      smp();
      n_st += int'(pif.md_start);
      n_bz += int'(pif.md_busy);
      n_sl += int'(pif.if_id_stall);
      tick();
    end
    chk("div_starts", n_st, 1);
    chk("div_busy", n_bz, 33);
    chk("div_stalls", n_sl, 34);

    // flush at DIV busy cycle 10
    for (int i = 0; i <= 10; i++) begin
      pif.ex_div = 1;
      pif.exc_flush = (i == 10);
      smp();
      if (i == 10)
        chk("flush_abort", int'(dut_o), 9'b000_111_011);
      tick();
    end
    clr();
    pif.ex_mult = 1;
    smp();
    chk("idle_after_flush", int'(pif.md_start), 1);
    tick();
    tick();
    tick();
    tick();
    clr();
    tick();

    // memory wait spanning end of MUL
    pif.ex_mult = 1;
    tick();
    pif.mem_req = 1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("done_hold", int'(dut_o), 9'b111_000_000);
      tick();
    end
    pif.mem_ok = 1;
    tick();
    clr();
    pif.ex_div = 1;
    smp();
    chk("idle_after_mw", int'(pif.md_start), 1);
    tick();
    clr();
    pif.exc_flush = 1;
    tick();
    clr();
    tick();

    // load-use + mult + memory wait together
    pif.ex_load = 1; pif.ex_regwen = 1; pif.ex_wreg = 3;
    pif.id_rs_ren = 1; pif.id_rs = 3;
    pif.ex_mult = 1; pif.mem_req = 1;
    smp();
    chk("simul", int'(dut_o), 9'b111_000_000);
    tick();
    pif.mem_ok = 1;
    tick();
    pif.mem_req = 0; pif.mem_ok = 0;
    tick();
    tick();
    clr();
    tick();
    tick();

    // both mult and div: div wins
    n_bz = 0;
    for (int i = 0; i < 36; i++) begin
      pif.ex_mult = (i < 35);
      pif.ex_div = (i < 35);
      smp();
      n_bz += int'(pif.md_busy);
      tick();
    end
    chk("div_wins", n_bz, 33);

    // reset mid-MUL
    pif.ex_mult = 1;
    tick();
    clr();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    smp();
    chk("reset_mid_mul", int'(dut_o), 0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
